float_mul_core: RTL and testbench
=================================

FLOAT_MUL_CORE -- requirements
Module: float_mul_core

Interface
REQ-001 Parameter EXP_WIDTH, default 8, exponent field width; parameter MAN_WIDTH, default 23, stored mantissa width; FLOAT_WIDTH = 1+EXP_WIDTH+MAN_WIDTH.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use one clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 in_a, in_b  input  FLOAT_WIDTH  IEEE-style operands.
REQ-007 out_valid  output  1  result valid.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 out_sign  output  1  product sign.
REQ-010 out_exp  output  EXP_WIDTH+2  unnormalised biased exponent, two's complement.
REQ-011 out_man  output  MAN_WIDTH+3  unnormalised product mantissa, unsigned.
REQ-012 out_nan, out_inf  output  1 each  special-result flags.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Acceptance: in IDLE, in_valid=1 at a rising edge latches in_a/in_b and enters CALC.
REQ-015 Unpack: exponent field 0 -> effective exponent 1, hidden bit 0; otherwise hidden bit 1; significand width MAN_WIDTH+1.
REQ-016 CALC SHALL run a radix-2 shift-add multiply, one significand bit per cycle, for exactly MAN_WIDTH+1 cycles, into a 2*MAN_WIDTH+2-bit product register; counter width ceil(log2(MAN_WIDTH+2)).
REQ-017 After the last iteration, CALC -> DONE; out_valid SHALL rise exactly MAN_WIDTH+2 edges after the acceptance edge.
REQ-018 out_man[MAN_WIDTH+1:0] = product[2*MAN_WIDTH+1:MAN_WIDTH] (truncation, no rounding); out_man[MAN_WIDTH+2] = 0.
REQ-019 out_exp = ea + eb - (2^(EXP_WIDTH-1)-1), computed in EXP_WIDTH+2 bits, signed; no saturation.
REQ-020 out_sign = sign(a) XOR sign(b) in all cases, including zero and NaN.
REQ-021 out_nan = 1 if either operand is NaN or one is infinity and the other zero; otherwise out_inf = 1 if either operand is infinity; when either flag is set, out_exp and out_man SHALL be 0.
REQ-022 In DONE, all outputs SHALL hold stable while out_ready=0; out_valid & out_ready at an edge -> IDLE.
REQ-023 No new operand is accepted in CALC or DONE, including in the handshake cycle; the earliest next acceptance is the edge after the DONE->IDLE transition.
REQ-024 in_a/in_b changes after acceptance SHALL NOT affect the result.

Reset
REQ-025 reset_n=0 SHALL asynchronously force IDLE; out_valid=0, in_ready=1, out_sign=0, out_exp=0, out_man=0, out_nan=0, out_inf=0, counter=0.
REQ-026 Reset asserted mid-CALC or in DONE SHALL discard the operation; no result is emitted after release.
REQ-027 First acceptance is possible on the first rising edge with reset_n=1.

Configuration
REQ-028 Macro FLOAT_MUL_EARLY_EXIT_EN defined: an operand pair with a zero (exponent and mantissa fields 0), NaN or infinity SHALL go IDLE -> DONE on the acceptance edge (out_valid one edge later, out_man=0 for zero operands).
REQ-029 Macro undefined: every operation SHALL take the full MAN_WIDTH+2-edge latency; results SHALL be identical.

Verification (EXP_WIDTH=8, MAN_WIDTH=23)
REQ-030 0x3F800000 x 0x3F800000 -> after 25 edges out_valid=1, sign 0, out_exp=0x07F, out_man=0x0800000, flags 0.
REQ-031 0xC0000000 x 0x40400000 -> sign 1, out_exp=0x081, out_man=0x0C00000.
REQ-032 0x00000001 x 0x3F800000 -> out_exp=0x001, out_man=0x0000001; 0x00800000 x 0x00800000 -> out_exp=0x383.
REQ-033 0x7F800000 x 0x00000000 -> out_nan=1, exp/man 0; 0x7F800000 x 0x3F800000 -> out_inf=1; with FLOAT_MUL_EARLY_EXIT_EN, out_valid after 1 edge, else 25.
REQ-034 out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE on the next edge.
REQ-035 reset_n pulsed low at CALC cycle 10 -> in_ready=1 and out_valid=0 immediately, with no out_valid before the next acceptance.

Source files
------------

// File: rtl/float_mul_core.sv
// Sequential floating-point multiplier core: radix-2 shift-add significand product with an
// unnormalised, unrounded result. Define FLOAT_MUL_EARLY_EXIT_EN to skip CALC for special operands.
module float_mul_core #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_sign,
    output logic [EXP_WIDTH+1:0]           out_exp,
    output logic [MAN_WIDTH+2:0]           out_man,
    output logic                           out_nan,
    output logic                           out_inf
);

    localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int SIG_W       = MAN_WIDTH + 1;
    localparam int PROD_W      = 2 * MAN_WIDTH + 2;
    localparam int CNT_W       = $clog2(MAN_WIDTH + 2);
    localparam int OEXP_W      = EXP_WIDTH + 2;
    localparam int BIAS        = 2 ** (EXP_WIDTH - 1) - 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SIG_W-1:0]    a_sig_q, a_sig_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                sign_q, sign_d;
    logic [OEXP_W-1:0]   exp_q, exp_d;
    logic [MAN_WIDTH+2:0] man_q, man_d;
    logic                nan_q, nan_d;
    logic                inf_q, inf_d;

    // Operand unpacking and classification
    logic [EXP_WIDTH-1:0] exp_a, exp_b, eff_exp_a, eff_exp_b;
    logic [MAN_WIDTH-1:0] man_a, man_b;
    logic [SIG_W-1:0]     sig_a, sig_b;
    logic                 zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic                 nan_in, inf_in, early_exit, accept, last_iter;
    logic [OEXP_W-1:0]    exp_sum;
    logic [SIG_W:0]       partial_sum;

    assign exp_a     = in_a[FLOAT_WIDTH-2 -: EXP_WIDTH];
    assign exp_b     = in_b[FLOAT_WIDTH-2 -: EXP_WIDTH];
    assign man_a     = in_a[MAN_WIDTH-1:0];
    assign man_b     = in_b[MAN_WIDTH-1:0];
    assign zero_a    = (exp_a == '0) && (man_a == '0);
    assign zero_b    = (exp_b == '0) && (man_b == '0);
    assign inf_a     = (exp_a == '1) && (man_a == '0);
    assign inf_b     = (exp_b == '1) && (man_b == '0);
    assign nan_a     = (exp_a == '1) && (man_a != '0);
    assign nan_b     = (exp_b == '1) && (man_b != '0);
    assign sig_a     = {exp_a != '0, man_a};
    assign sig_b     = {exp_b != '0, man_b};
    // Subnormals share the exponent of the smallest normal, just without the hidden bit.
    assign eff_exp_a = (exp_a == '0) ? EXP_WIDTH'(1) : exp_a;
    assign eff_exp_b = (exp_b == '0) ? EXP_WIDTH'(1) : exp_b;
    assign exp_sum   = OEXP_W'(eff_exp_a) + OEXP_W'(eff_exp_b) - OEXP_W'(BIAS);
    assign nan_in    = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
    assign inf_in    = ~nan_in & (inf_a | inf_b);

`ifdef FLOAT_MUL_EARLY_EXIT_EN
    assign early_exit = zero_a | zero_b | nan_a | nan_b | inf_a | inf_b;
`else
    assign early_exit = 1'b0;
`endif

    assign accept    = (state_q == IDLE) && in_valid;
    assign last_iter = (state_q == CALC) && (cnt_q == CNT_W'(MAN_WIDTH));

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sig_q <= '0;
            prod_q  <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sig_q <= a_sig_d;
            prod_q  <= prod_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
        end
    end

    // NOTE: every always_comb output is given a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = early_exit ? DONE : CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        cnt_d       = cnt_q;
        a_sig_d     = a_sig_q;
        prod_d      = prod_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        man_d       = man_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        partial_sum = {1'b0, prod_q[PROD_W-1:SIG_W]} + (prod_q[0] ? {1'b0, a_sig_q} : '0);
        if (accept) begin
            cnt_d   = '0;
            a_sig_d = sig_a;
            prod_d  = {{SIG_W{1'b0}}, sig_b};
            sign_d  = in_a[FLOAT_WIDTH-1] ^ in_b[FLOAT_WIDTH-1];
            exp_d   = (nan_in | inf_in) ? '0 : exp_sum;
            man_d   = '0;
            nan_d   = nan_in;
            inf_d   = inf_in;
        end else if (state_q == CALC) begin
            // Upper half accumulates the multiplicand while the multiplier shifts out the bottom.
            prod_d = {partial_sum, prod_q[MAN_WIDTH:1]};
            cnt_d  = last_iter ? '0 : cnt_q + CNT_W'(1);
            if (last_iter)
                man_d = (nan_q | inf_q) ? '0 : {1'b0, prod_d[PROD_W-1:MAN_WIDTH]};
        end
    end

    assign out_sign = sign_q;
    assign out_exp  = exp_q;
    assign out_man  = man_q;
    assign out_nan  = nan_q;
    assign out_inf  = inf_q;

endmodule

// File: tb/tb_float_mul_core.sv
// Self-checking bench for float_mul_core (EXP_WIDTH=8, MAN_WIDTH=23): directed vectors,
// random operands against an arithmetic reference model, handshake stall and mid-CALC reset.
module tb_float_mul_core;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [25:0] out_man;
    logic        out_nan, out_inf;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef FLOAT_MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    float_mul_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_man   (out_man),
        .out_nan   (out_nan),
        .out_inf   (out_inf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: real significand product by integer multiply, exponent by integer arithmetic.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [38:0] res, output int latency);
        int     ea, eb, ma, mb, e_int;
        longint sa, sb, prod;
        bit     za, zb, ia, ib, na, nb, nan, inf;
        logic [9:0]  e;
        logic [25:0] m;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        ma = int'(a[22:0]);  mb = int'(b[22:0]);
        za = (ea == 0) && (ma == 0);   zb = (eb == 0) && (mb == 0);
        ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
        na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
        nan = na || nb || (ia && zb) || (ib && za);
        inf = !nan && (ia || ib);
        sa = longint'(ma) + ((ea != 0) ? 64'd8388608 : 64'd0);
        sb = longint'(mb) + ((eb != 0) ? 64'd8388608 : 64'd0);
        prod  = (sa * sb) / 64'd8388608;
        e_int = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 127;
        e = 10'(e_int);
        m = 26'(prod);
        if (nan || inf) begin
            e = '0;
            m = '0;
        end
        res = {a[31] ^ b[31], e, m, nan, inf};
        latency = (EARLY && (za || zb || ia || ib || na || nb)) ? 1 : 25;
    endfunction

    logic [38:0] obs_res;

    // Drives one operand pair, checks latency and result, then completes the handshake
    // after hold_cycles of back-pressure (with ignored in_valid pulses during the stall).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit wait_neg,
                          input int hold_cycles, input string tag);
        logic [38:0] exp_res;
        int          exp_lat, n;
        ref_mul(a, b, exp_res, exp_lat);
        if (wait_neg) @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom;
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        obs_res = {out_sign, out_exp, out_man, out_nan, out_inf};
        check({tag, "_result"}, 64'(obs_res), 64'(exp_res));
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_a = $urandom; in_b = $urandom;
            @(posedge clk); #1;
            check({tag, "_hold"}, 64'({out_valid, in_ready, out_sign, out_exp, out_man, out_nan, out_inf}),
                  64'({2'b10, exp_res}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_release"}, 64'({out_valid, in_ready}), 64'b01);
        @(posedge clk); #1;
        check({tag, "_no_accept"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[30:23] = 8'h00;
            1: r[30:23] = 8'hFF;
            2: r[30:0]  = '0;
            3: begin r[30:23] = 8'hFF; r[22:0] = '0; end
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        bit seen_valid;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        #3;
        check("reset_state", 64'({in_ready, out_valid, out_sign, out_exp, out_man, out_nan, out_inf}),
              64'({2'b10, 39'd0}));
        #9;
        reset_n = 1'b1;

        // First acceptance on the first rising edge after reset release.
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 0, "one_x_one");
        check("one_x_one_exp", 64'(obs_res[37:28]), 64'h07F);
        check("one_x_one_man", 64'(obs_res[27:2]), 64'h080_0000);
        check("one_x_one_flags", 64'({obs_res[38], obs_res[1:0]}), 64'd0);

        run_op(32'hC000_0000, 32'h4040_0000, 1'b1, 0, "m2_x_3");
        check("m2_x_3_fields", 64'({obs_res[38], obs_res[37:28], obs_res[27:2]}),
              64'({1'b1, 10'h081, 26'h0C0_0000}));

        run_op(32'h0000_0001, 32'h3F80_0000, 1'b1, 0, "denorm_x_one");
        check("denorm_x_one_fields", 64'({obs_res[37:28], obs_res[27:2]}), 64'({10'h001, 26'h1}));

        run_op(32'h0080_0000, 32'h0080_0000, 1'b1, 0, "min_x_min");
        check("min_x_min_exp", 64'(obs_res[37:28]), 64'h383);

        run_op(32'h7F80_0000, 32'h0000_0000, 1'b1, 0, "inf_x_zero");
        check("inf_x_zero_nan", 64'({obs_res[1:0], obs_res[37:2]}), 64'({2'b10, 36'd0}));

        run_op(32'h7F80_0000, 32'h3F80_0000, 1'b1, 0, "inf_x_one");
        check("inf_x_one_inf", 64'(obs_res[1:0]), 64'b01);

        run_op(32'h8000_0000, 32'h7FC0_0001, 1'b1, 0, "zero_x_nan");

        // Back-pressure: result must hold for 10 stalled cycles.
        run_op(32'h4049_0FDB, 32'hBF00_0000, 1'b1, 10, "stall");

        for (int i = 0; i < 20; i++)
            run_op(rand_op(), rand_op(), 1'b1, i % 3, "random");

        // Reset asserted around CALC cycle 10 discards the operation.
        @(negedge clk);
        in_a = 32'h3FC0_0000; in_b = 32'h4000_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midcalc_reset", 64'({in_ready, out_valid, out_sign, out_exp, out_man, out_nan, out_inf}),
              64'({2'b10, 39'd0}));
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        out_ready = 1'b0;
        check("reset_discard", 64'({seen_valid, in_ready}), 64'b01);

        run_op(32'h3F80_0000, 32'h4000_0000, 1'b1, 0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
